usb_rx_nrzi_deserializer: RTL and testbench
===========================================

# usb_rx_nrzi_deserializer

Receive-path stage downstream of the USB packet FSM. While the packet FSM holds `data_enable` high, this block:
- NRZI-decodes the sampled line state,
- removes stuffed bits and detects stuffing violations,
- assembles LSB-first bytes for the protocol layer.

At end of packet it reports byte alignment and pulses an end-of-packet strobe.

## Interface
Reset scheme: one clock; reset is asynchronous and active-low.

Parameters:
- `J_STATE`, 2'b10, line-state code for J (full speed; swap with `K_STATE` for low speed)
- `K_STATE`, 2'b01, line-state code for K
- `STUFF_LEN`, 6, consecutive decoded ones after which a stuffed zero is mandatory

Ports:
- `clk`  in  1  bit-domain clock
- `reset_n`  in  1  asynchronous active-low reset
- `bit_strobe`  in  1  one-cycle sample enable from clock recovery; tie 1 for one bit per clk
- `usb_line_state`  in  2  synchronised {D+,D-}, the same signal the packet FSM sees
- `data_enable`  in  1  high while packet FSM is in DATA
- `rx_data`  out  8  assembled byte, valid with `rx_valid`
- `rx_valid`  out  1  one-cycle byte strobe
- `rx_active`  out  1  registered copy of `data_enable`
- `rx_stuff_err`  out  1  one-cycle pulse on stuffing violation or SE1 in packet
- `rx_align_err`  out  1  one-cycle pulse at packet end if 2..7 leftover bits
- `rx_eop`  out  1  one-cycle pulse when the packet ends

## Operation
- **Sampled bit:** a cycle with `bit_strobe`=1 and `usb_line_state` ∈ {J,K}. SE0 and SE1 samples are never data bits.
- **`prev_level`:**
  - Updated on every sampled bit regardless of `data_enable`, so it holds the final SYNC K at packet start.
  - Reset value: J.
- **NRZI decode:** decoded bit = 1 if the level equals `prev_level`; 0 on a transition.
- **Rising edge of `data_enable`:** `ones_cnt`←1 (the trailing SYNC one counts toward stuffing), `bit_cnt`←0, `halted`←0.
- **Ones counting and stuffing:**
  - With `data_enable`=1, not halted, on each sampled bit:
    - decoded 1 → `ones_cnt`+1;
    - decoded 0 → `ones_cnt`←0.
  - When `ones_cnt`==`STUFF_LEN`, the next sampled bit is a stuff bit and is discarded:
    - if it is 0 → `ones_cnt`←0;
    - if it is 1 → `rx_stuff_err` pulse and `halted`←1.
- **SE1 while `data_enable`=1 and not halted:** `rx_stuff_err` pulse, `halted`←1.
- **Halted:** no further `rx_valid` until `data_enable` falls.
- **Byte assembly:**
  - Each non-stuff decoded bit shifts into the MSB of a shift register (LSB-first wire order); `bit_cnt`+1.
  - On the 8th bit: `rx_data`←shifted byte, `rx_valid` pulse, `bit_cnt`←0.
- **Falling edge of `data_enable`:**
  - `rx_eop` pulse.
  - `bit_cnt` ∈ {0,1} is accepted; a single leftover bit is a dribble bit and is discarded.
  - `bit_cnt` ∈ 2..7 and not halted → `rx_align_err` pulse together with `rx_eop`.
  - A halted packet reports only `rx_stuff_err`.

## Timing
- **Reset values:** `rx_data`=0x00; `rx_valid`, `rx_active`, `rx_stuff_err`, `rx_align_err`, `rx_eop`=0. Internally `prev_level`=J, counters 0, not halted.
- **Latency:**
  - `rx_valid`/`rx_data` register one clk after the strobe cycle carrying the byte's 8th bit.
  - `rx_stuff_err` registers one clk after the offending sample.
- **End of packet:** `rx_eop` and `rx_align_err` assert one clk after the first cycle with `data_enable`=0. `rx_active` falls on the same clk edge.
- **Simultaneous events:**
  - A stuff violation can never coincide with a byte completion, because the offending bit is not a data bit.
  - A strobe in the cycle where `data_enable` is already 0 is ignored for data but still updates `prev_level`.
  - `data_enable` rise and fall in consecutive cycles → `rx_eop` with no `rx_valid` and no `rx_align_err`.
- **Reset mid-packet:** all state returns to reset values immediately (asynchronous). No `rx_eop` is generated for the aborted packet.
- **Output pulses:** all error/strobe outputs are single-cycle pulses, never sticky.

## Structure
- **Shared USB PHY package:** line-state codes (SE0=2'b00, J, K, SE1=2'b11) and the stuff length. The packet FSM should migrate to the same constants.
- **Natural sub-module:** `usb_nrzi_unstuff`, which owns `prev_level` and `ones_cnt` and emits `{bit_valid, bit, stuff_err}`. The parent keeps the byte shifter, `bit_cnt`, and the EOP/alignment logic.

## Test plan
- **Single byte:** SYNC ending KK, then decoded bits 1,0,1,0,0,1,0,1, then SE0,SE0,J → one `rx_valid` with `rx_data`=0xA5, then `rx_eop`=1, `rx_align_err`=0.
- **Stuffing:** after SYNC, decoded 1,1,1,1,1,0(stuff),1,1,1 → `rx_data`=0xFF, stuff bit dropped, no error.
- **Stuff violation:** after SYNC, decoded 1×5 then 1 → `rx_stuff_err` pulse, no `rx_valid` for rest of packet, `rx_eop` pulse with `rx_align_err`=0.
- **Alignment:** 0xC3 followed by 3 extra bits → one `rx_valid` (0xC3), `rx_align_err`=1 with `rx_eop`. With 1 extra bit instead → `rx_align_err`=0.
- **Strobe gating:** `bit_strobe` high 1 cycle in 4, byte 0x5A → 0x5A received. Idle cycles leave counters unchanged.
- **Reset mid-byte:** assert `reset_n`=0 after 4 bits → all outputs 0 at once. A following packet with 0x01 decodes correctly.

Source files
------------

// File: rtl/usb_rx_nrzi_deserializer_pkg.sv
// Shared USB PHY constants: line-state codes and bit-stuffing run length.
// Intended for both the packet FSM and the receive deserializer.
package usb_rx_nrzi_deserializer_pkg;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/usb_rx_nrzi_deserializer_if.sv
// Bundle between the line sampler / packet FSM side and the deserializer.
// master drives samples and data_enable, slave returns the byte stream.
interface usb_rx_nrzi_deserializer_if;

    logic       bit_strobe;
    logic [1:0] usb_line_state;
    logic       data_enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_stuff_err;
    logic       rx_align_err;
    logic       rx_eop;

    modport master (
        output bit_strobe, usb_line_state, data_enable,
        input  rx_data, rx_valid, rx_active,
        input  rx_stuff_err, rx_align_err, rx_eop
    );

    modport slave (
        input  bit_strobe, usb_line_state, data_enable,
        output rx_data, rx_valid, rx_active,
        output rx_stuff_err, rx_align_err, rx_eop
    );

endinterface

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and stuffed-bit remover; owns prev_level and ones_cnt.
// Emits one decoded data bit per accepted sample, or a stuffing error.
module usb_nrzi_unstuff
    import usb_rx_nrzi_deserializer_pkg::*;
#(
    parameter logic [1:0] J_STATE   = LS_J,
    parameter logic [1:0] K_STATE   = LS_K,
    parameter int         STUFF_LEN = USB_STUFF_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe_i,
    input  logic [1:0] line_i,
    input  logic       en_i,
    input  logic       start_i,
    output logic       bit_valid_o,
    output logic       bit_o,
    output logic       stuff_err_o
);

    localparam int CW = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(STUFF_LEN);

    logic [1:0]    prev_q, prev_d;
    logic [CW-1:0] ones_q, ones_d, ones_e;
    logic          sample;
    logic          dec;

    always_comb begin
        sample      = strobe_i &&
                      (line_i == J_STATE || line_i == K_STATE);
        dec         = (line_i == prev_q);
        prev_d      = sample ? line_i : prev_q;
        // the final SYNC one counts toward the first stuffing run
        ones_e      = start_i ? CW'(1) : ones_q;
        ones_d      = ones_e;
        bit_valid_o = 1'b0;
        bit_o       = dec;
        stuff_err_o = 1'b0;
        if (en_i && strobe_i && line_i == LS_SE1) begin
            stuff_err_o = 1'b1;
        end else if (en_i && sample) begin
            if (ones_e == FULL) begin
                ones_d      = '0;
                stuff_err_o = dec;
            end else begin
                bit_valid_o = 1'b1;
                ones_d      = dec ? ones_e + CW'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= J_STATE;
            ones_q <= '0;
        end else begin
            prev_q <= prev_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_nrzi_deserializer.sv
// USB receive deserializer: unstuffed bits to LSB-first bytes, with
// end-of-packet strobe and byte-alignment check.
module usb_rx_nrzi_deserializer
    import usb_rx_nrzi_deserializer_pkg::*;
#(
    parameter logic [1:0] J_STATE   = LS_J,
    parameter logic [1:0] K_STATE   = LS_K,
    parameter int         STUFF_LEN = USB_STUFF_LEN
) (
    input logic                         clk,
    input logic                         reset_n,
    usb_rx_nrzi_deserializer_if.slave   bus
);

    logic       rise, fall, en, halted_e;
    logic       bit_valid, bit_val, stuff_err;
    logic [2:0] cnt_q, cnt_d, cnt_e;
    logic [7:0] sh_q, sh_d, data_q, data_d;
    logic       valid_q, valid_d, active_q, active_d;
    logic       serr_q, serr_d, aerr_q, aerr_d;
    logic       eop_q, eop_d, halted_q, halted_d;

    usb_nrzi_unstuff #(
        .J_STATE   (J_STATE),
        .K_STATE   (K_STATE),
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuff (
        .clk         (clk),
        .rst_n       (reset_n),
        .strobe_i    (bus.bit_strobe),
        .line_i      (bus.usb_line_state),
        .en_i        (en),
        .start_i     (rise),
        .bit_valid_o (bit_valid),
        .bit_o       (bit_val),
        .stuff_err_o (stuff_err)
    );

    always_comb begin
        rise     = bus.data_enable && !active_q;
        fall     = !bus.data_enable && active_q;
        halted_e = rise ? 1'b0 : halted_q;
        cnt_e    = rise ? 3'd0 : cnt_q;
        en       = bus.data_enable && !halted_e;
        cnt_d    = cnt_e;
        sh_d     = sh_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        serr_d   = stuff_err;
        halted_d = halted_e || stuff_err;
        active_d = bus.data_enable;
        eop_d    = fall;
        // one leftover bit is a dribble bit and is tolerated
        aerr_d   = fall && !halted_q && cnt_q >= 3'd2;
        if (bit_valid) begin
            sh_d = {bit_val, sh_q[7:1]};
            if (cnt_e == 3'd7) begin
                data_d  = sh_d;
                valid_d = 1'b1;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_e + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= 3'd0;
            sh_q     <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            serr_q   <= 1'b0;
            aerr_q   <= 1'b0;
            eop_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            serr_q   <= serr_d;
            aerr_q   <= aerr_d;
            eop_q    <= eop_d;
            halted_q <= halted_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_active    = active_q;
    assign bus.rx_stuff_err = serr_q;
    assign bus.rx_align_err = aerr_q;
    assign bus.rx_eop       = eop_q;

endmodule

// File: tb/tb_usb_rx_nrzi_deserializer.sv
// Bench for usb_rx_nrzi_deserializer: NRZI-encoded packet table,
// byte scoreboard, plus SE1 and mid-packet reset sequences.
module tb_usb_rx_nrzi_deserializer;
    import usb_rx_nrzi_deserializer_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    usb_rx_nrzi_deserializer_if bus();

    usb_rx_nrzi_deserializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] bits;
        int          n;
        int          gap;
        int          nb;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          serr;
        int          aerr;
    } vec_t;

    int total = 0;
    int bad = 0;
    int eop_n = 0;
    int align_n = 0;
    int stuff_n = 0;
    int valid_n = 0;
    logic [7:0] expq[$];
    logic [1:0] cur = LS_J;
    vec_t vecs[9];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_n++;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL byte_extra: got %0h want none", bus.rx_data);
            end else begin
                chk("byte", {24'h0, bus.rx_data}, {24'h0, expq.pop_front()});
            end
        end
        if (bus.rx_eop) eop_n++;
        if (bus.rx_stuff_err) stuff_n++;
        if (bus.rx_align_err) begin
            align_n++;
            chk("align_with_eop", {31'h0, bus.rx_eop}, 32'd1);
        end
    end

    task automatic cyc(logic s, logic [1:0] ls, logic de);
        bus.bit_strobe     = s;
        bus.usb_line_state = ls;
        bus.data_enable    = de;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_pre();
        logic [1:0] sy[8];
        sy = '{LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K};
        repeat (2) cyc(1'b0, LS_J, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, sy[i], 1'b0);
        cur = LS_K;
    endtask

    task automatic bit_out(logic b, int gap);
        if (!b) cur = (cur == LS_J) ? LS_K : LS_J;
        cyc(1'b1, cur, 1'b1);
        repeat (gap) cyc(1'b0, cur, 1'b1);
    endtask

    task automatic eop_seq();
        cyc(1'b1, LS_SE0, 1'b0);
        cyc(1'b1, LS_SE0, 1'b0);
        cyc(1'b1, LS_J, 1'b0);
        cur = LS_J;
        repeat (3) cyc(1'b0, LS_J, 1'b0);
    endtask

    task automatic run_vec(vec_t v);
        int e0, a0, s0, v0;
        e0 = eop_n; a0 = align_n; s0 = stuff_n; v0 = valid_n;
        if (v.nb > 0) expq.push_back(v.b0);
        if (v.nb > 1) expq.push_back(v.b1);
        sync_pre();
        for (int i = 0; i < v.n; i++) bit_out(v.bits[v.n-1-i], v.gap);
        eop_seq();
        chk({v.name, "_eop"}, eop_n - e0, 1);
        chk({v.name, "_nvalid"}, valid_n - v0, v.nb);
        chk({v.name, "_stuff"}, stuff_n - s0, v.serr);
        chk({v.name, "_align"}, align_n - a0, v.aerr);
        chk({v.name, "_pending"}, expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        int e0, s0, v0, a0;
        // bits are listed in wire order, first bit in the MSB of the n-bit field
        vecs[0] = '{"a5",    32'b10100101,         8, 0, 1, 8'hA5, 8'h00, 0, 0};
        vecs[1] = '{"stuff", 32'b111110111,        9, 0, 1, 8'hFF, 8'h00, 0, 0};
        vecs[2] = '{"viol",  32'b1111110101,      10, 0, 0, 8'h00, 8'h00, 1, 0};
        vecs[3] = '{"c3p3",  32'b11000011010,     11, 0, 1, 8'hC3, 8'h00, 0, 1};
        vecs[4] = '{"c3p1",  32'b110000110,        9, 0, 1, 8'hC3, 8'h00, 0, 0};
        vecs[5] = '{"gap",   32'b01011010,         8, 3, 1, 8'h5A, 8'h00, 0, 0};
        vecs[6] = '{"two",   32'b00000000111111011, 17, 0, 2, 8'h00, 8'hFF, 0, 0};
        vecs[7] = '{"drib",  32'b1,                1, 0, 0, 8'h00, 8'h00, 0, 0};
        vecs[8] = '{"left2", 32'b10,               2, 0, 0, 8'h00, 8'h00, 0, 1};

        bus.bit_strobe = 1'b0;
        bus.usb_line_state = LS_J;
        bus.data_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",   {24'h0, bus.rx_data}, 32'h0);
        chk("rst_valid",  {31'h0, bus.rx_valid}, 32'h0);
        chk("rst_active", {31'h0, bus.rx_active}, 32'h0);
        chk("rst_stuff",  {31'h0, bus.rx_stuff_err}, 32'h0);
        chk("rst_align",  {31'h0, bus.rx_align_err}, 32'h0);
        chk("rst_eop",    {31'h0, bus.rx_eop}, 32'h0);
        reset_n = 1'b1;
        cyc(1'b0, LS_J, 1'b0);

        // SE1 inside the packet halts it
        e0 = eop_n; s0 = stuff_n; v0 = valid_n; a0 = align_n;
        sync_pre();
        bit_out(1'b1, 0); bit_out(1'b0, 0); bit_out(1'b1, 0);
        cyc(1'b1, LS_SE1, 1'b1);
        for (int i = 0; i < 9; i++) bit_out(i[0], 0);
        eop_seq();
        chk("se1_stuff", stuff_n - s0, 1);
        chk("se1_nvalid", valid_n - v0, 0);
        chk("se1_align", align_n - a0, 0);
        chk("se1_eop", eop_n - e0, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // reset mid-byte: outputs clear immediately, no eop afterwards
        e0 = eop_n;
        sync_pre();
        bit_out(1'b1, 0); bit_out(1'b0, 0); bit_out(1'b0, 0); bit_out(1'b1, 0);
        chk("pre_rst_active", {31'h0, bus.rx_active}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_data", {24'h0, bus.rx_data}, 32'h0);
        chk("mid_rst_active", {31'h0, bus.rx_active}, 32'h0);
        chk("mid_rst_eop", {31'h0, bus.rx_eop}, 32'h0);
        bus.data_enable = 1'b0;
        bus.bit_strobe = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) cyc(1'b0, LS_J, 1'b0);
        chk("mid_rst_no_eop", eop_n - e0, 0);
        run_vec('{"post_rst", 32'b10000000, 8, 0, 1, 8'h01, 8'h00, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
